rtc_mc_bus_fsm: RTL

- Host-side bus front end of the Microcontroller Interface. Sits directly upstream of the read channel and the write channel.
- Converts asynchronous-style host chip-select/strobe cycles into one qualified internal access: enable, address, write data, then a single-cycle acknowledge after a programmable number of wait states.
- Captures the read channel's gated data output during the acknowledge cycle and holds it for the host until the cycle ends.

---
 rtl/rtc_mc_bus_fsm.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rtc_mc_bus_fsm.sv
// rtl/rtc_mc_bus_fsm.sv - host bus front end turning chip-select/strobe cycles into one qualified internal access
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_cs, i_rd, i_wr          host chip select and read/write strobes
//   i_host_addr, i_host_wdata host address and write data
//   o_host_rdata              read data held for the host until the cycle ends
//   o_host_ready              access complete, held until i_cs drops
//   o_err                     one-cycle pulse: illegal strobe pair or aborted access
//   o_rd_en, o_wr_en          enables to the read / write channel
//   o_addr, o_wdata           latched address / write data to the channels
//   o_ack                     one-cycle acknowledge to the channels
//   i_rd_data                 gated read data from the read channel

module rtc_mc_bus_fsm #(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_cs,
  input  logic        i_rd,
  input  logic        i_wr,
  input  logic [5:0]  i_host_addr,
  input  logic [31:0] i_host_wdata,
  output logic [31:0] o_host_rdata,
  output logic        o_host_ready,
  output logic        o_err,
  output logic        o_rd_en,
  output logic        o_wr_en,
  output logic [5:0]  o_addr,
  output logic [31:0] o_wdata,
  output logic        o_ack,
  input  logic [31:0] i_rd_data
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_ACK    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               lock_q, lock_d;
  logic [31:0]        host_rdata_q, host_rdata_d;
  logic               host_ready_q, host_ready_d;
  logic               err_q, err_d;
  logic               rd_en_q, rd_en_d;
  logic               wr_en_q, wr_en_d;
  logic [5:0]         addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               ack_q, ack_d;

  logic req_rd, req_wr, req_bad;

  assign req_rd  = i_cs & i_rd & ~i_wr;
  assign req_wr  = i_cs & i_wr & ~i_rd;
  assign req_bad = i_cs & i_rd & i_wr;

  // Every output is the registered copy of its *_d value, so the host and
  // channels never see combinational paths through the state decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lock_d       = 1'b0;
    host_rdata_d = host_rdata_q;
    host_ready_d = host_ready_q;
    err_d        = 1'b0;
    ack_d        = 1'b0;
    rd_en_d      = rd_en_q;
    wr_en_d      = wr_en_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_bad) begin
          // Pulse once per illegal episode; lock holds off repeats while
          // both strobes stay high.
          err_d  = ~lock_q;
          lock_d = 1'b1;
        end else if (req_rd || req_wr) begin
          addr_d  = i_host_addr;
          if (req_wr) begin
            wdata_d = i_host_wdata;
          end
          rd_en_d = req_rd;
          wr_en_d = req_wr;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (!i_cs) begin
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          ack_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_ACK: begin
        // Read data is captured on the edge leaving ACK, while the read
        // channel is still enabled and driving its gated output.
        if (rd_en_q) begin
          host_rdata_d = i_rd_data;
        end
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        host_ready_d = 1'b1;
        state_d      = S_DONE;
      end

      S_DONE: begin
        if (!i_cs) begin
          host_ready_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      lock_q       <= 1'b0;
      host_rdata_q <= '0;
      host_ready_q <= 1'b0;
      err_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lock_q       <= lock_d;
      host_rdata_q <= host_rdata_d;
      host_ready_q <= host_ready_d;
      err_q        <= err_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ack_q        <= ack_d;
    end
  end

  assign o_host_rdata = host_rdata_q;
  assign o_host_ready = host_ready_q;
  assign o_err        = err_q;
  assign o_rd_en      = rd_en_q;
  assign o_wr_en      = wr_en_q;
  assign o_addr       = addr_q;
  assign o_wdata      = wdata_q;
  assign o_ack        = ack_q;

endmodule
